// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter.
//   own_t       : owner tag carried by an in-flight VRAM read (none / CPU / VGA)
//   cpu_state_t : CPU-side FSM states (idle, waiting for read data)
package vram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VGA  = 2'd2
    } own_t;

    typedef enum logic {
        C_IDLE    = 1'b0,
        C_RD_WAIT = 1'b1
    } cpu_state_t;

endpackage

// File: rtl/vram_arbiter_rd_pipe.sv
// Read-return path of the VRAM arbiter.
// An RD_LAT-deep shift register of owner tags follows each read issued to
// the VRAM.  When a tag leaves the pipe, the VRAM read data belongs to that
// owner and is steered to the CPU or VGA side.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   issue_tag     owner of the read issued this cycle (OWN_NONE if none)
//   vram_rdata    read data from the VRAM
//   cpu_done      CPU read data valid this cycle
//   cpu_rdata     CPU read data (holds last CPU read value otherwise)
//   vga_rvalid    VGA read data valid this cycle
//   vga_rdata     VGA read data (holds last VGA read value otherwise)
module vram_arbiter_rd_pipe
    import vram_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  own_t              issue_tag,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata
);

    own_t              tag_q [RD_LAT];
    own_t              out_tag;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vga_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) tag_q[i] <= OWN_NONE;
        end else begin
            tag_q[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign out_tag = tag_q[RD_LAT-1];

    // The hold registers keep the last delivered word so the data outputs
    // do not wander when no read is completing.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            if (out_tag == OWN_CPU) cpu_rdata_q <= vram_rdata;
            if (out_tag == OWN_VGA) vga_rdata_q <= vram_rdata;
        end
    end

    assign cpu_done   = ~rst & (out_tag == OWN_CPU);
    assign vga_rvalid = ~rst & (out_tag == OWN_VGA);
    assign cpu_rdata  = cpu_done   ? vram_rdata : cpu_rdata_q;
    assign vga_rdata  = vga_rvalid ? vram_rdata : vga_rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter for the single-port video RAM shared by the CPU VRAM window and the
// VGA scan-out fetcher.  One access slot per cycle.  VGA has priority; CPU
// writes are posted into a one-entry buffer; a starvation counter forces a
// CPU-side grant after STARVE_MAX consecutive denied cycles.
// Handshakes:
//   cpu_req is a level held until the single-cycle cpu_ack.  Writes are
//   acknowledged when captured into the buffer; reads when data is returned.
//   vga_req is sampled every cycle; vga_gnt marks the address accepted, and
//   vga_rvalid follows RD_LAT cycles later.  Denied VGA requests are dropped.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU access request
//   cpu_ack, cpu_rdata             CPU completion and read data
//   vga_req, vga_addr              VGA fetch request
//   vga_gnt, vga_rvalid, vga_rdata VGA grant and read return
//   vram_addr/we/wdata, vram_rdata VRAM interface
//   cpu_state_dbg, wbuf_valid_dbg  CPU FSM state and write-buffer occupancy
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata,
    output cpu_state_t        cpu_state_dbg,
    output logic              wbuf_valid_dbg
);

    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    cpu_state_t        cpu_state, cpu_state_nxt;
    logic              wbuf_valid;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [DATA_W-1:0] wbuf_data;
    logic [SC_W-1:0]   starve_cnt;

    logic cpu_rd_req, cpu_side_pending, force_cpu;
    logic grant_cpu, grant_vga, drain, cpu_rd_grant, wr_accept, rd_cpu_done;
    own_t issue_tag;

    always_comb begin
        // A read waits for an empty write buffer so it never overtakes a
        // posted write to the same address.
        cpu_rd_req       = (cpu_state == C_IDLE) & cpu_req & ~cpu_we & ~wbuf_valid;
        cpu_side_pending = wbuf_valid | cpu_rd_req;
        force_cpu        = (starve_cnt == STARVE_LIM) & cpu_side_pending;
        grant_cpu        = ~rst & (force_cpu | (~vga_req & cpu_side_pending));
        grant_vga        = ~rst & vga_req & ~force_cpu;
        drain            = grant_cpu & wbuf_valid;
        cpu_rd_grant     = grant_cpu & ~wbuf_valid;
        // The buffer may accept a new write in the same cycle it drains.
        wr_accept        = ~rst & (cpu_state == C_IDLE) & cpu_req & cpu_we
                           & (~wbuf_valid | drain);

        vram_addr  = '0;
        vram_we    = 1'b0;
        vram_wdata = '0;
        issue_tag  = OWN_NONE;
        if (drain) begin
            vram_addr  = wbuf_addr;
            vram_we    = 1'b1;
            vram_wdata = wbuf_data;
        end else if (cpu_rd_grant) begin
            vram_addr  = cpu_addr;
            issue_tag  = OWN_CPU;
        end else if (grant_vga) begin
            vram_addr  = vga_addr;
            issue_tag  = OWN_VGA;
        end
    end

    always_comb begin
        cpu_state_nxt = cpu_state;
        case (cpu_state)
            C_IDLE:    if (cpu_rd_grant) cpu_state_nxt = C_RD_WAIT;
            C_RD_WAIT: if (rd_cpu_done)  cpu_state_nxt = C_IDLE;
            default:                     cpu_state_nxt = C_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) cpu_state <= C_IDLE;
        else     cpu_state <= cpu_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbuf_valid <= 1'b0;
            wbuf_addr  <= '0;
            wbuf_data  <= '0;
        end else if (wr_accept) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= cpu_addr;
            wbuf_data  <= cpu_wdata;
        end else if (drain) begin
            wbuf_valid <= 1'b0;
        end
    end

    // Counts cycles the CPU side waited behind VGA; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst || grant_cpu || !cpu_side_pending) begin
            starve_cnt <= '0;
        end else if (grant_vga && starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    vram_arbiter_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .issue_tag  (issue_tag),
        .vram_rdata (vram_rdata),
        .cpu_done   (rd_cpu_done),
        .cpu_rdata  (cpu_rdata),
        .vga_rvalid (vga_rvalid),
        .vga_rdata  (vga_rdata)
    );

    assign cpu_ack        = wr_accept | rd_cpu_done;
    assign vga_gnt        = grant_vga;
    assign cpu_state_dbg  = cpu_state;
    assign wbuf_valid_dbg = wbuf_valid;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 200;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              cpu_req, cpu_we, cpu_ack;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              vga_req, vga_gnt, vga_rvalid;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_wdata, vram_rdata;
    cpu_state_t        cpu_state_dbg;
    logic              wbuf_valid_dbg;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata),
        .cpu_state_dbg(cpu_state_dbg), .wbuf_valid_dbg(wbuf_valid_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference contents ----------------
    // Power-up VRAM contents; 0x0100 preloaded with 0x3C.
    function automatic logic [7:0] init_val(input logic [15:0] a);
        if (a == 16'h0100) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // VRAM model: RD_LAT-cycle read pipeline, writes at the clock edge.
    logic [7:0] mem_w [int];
    logic [7:0] rd_sh [RD_LAT];

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        if (mem_w.exists(int'(a))) return mem_w[int'(a)];
        return init_val(a);
    endfunction

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rd_sh[i] <= rd_sh[i-1];
        rd_sh[0] <= mem_rd(vram_addr);
        if (vram_we) mem_w[int'(vram_addr)] = vram_wdata;
    end
    assign vram_rdata = rd_sh[RD_LAT-1];

    // Program-order view of memory as the CPU sees it.
    logic [7:0] shadow [int];
    function automatic logic [7:0] shadow_rd(input logic [15:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return init_val(a);
    endfunction

    // ---------------- scoreboard queues ----------------
    logic [7:0]  cpu_rd_exp_q[$];
    logic [23:0] wr_exp_q[$];
    logic [7:0]  vga_exp_q[$];
    int          vga_due_q[$];

    // ---------------- VGA driver ----------------
    // mode 0: idle, 1: continuous sequential fetch, 2: random fetch
    int         vga_mode = 1;
    logic       vga_gnt_seen = 1'b0;
    logic [7:0] vga_ptr = 8'h0;

    always @(posedge clk) begin
        #2;
        case (vga_mode)
            0: vga_req = 1'b0;
            1: begin
                if (vga_gnt_seen) vga_ptr = vga_ptr + 8'd1;
                vga_req  = 1'b1;
                vga_addr = {8'h80, vga_ptr};
            end
            default: begin
                if (!(vga_req && !vga_gnt_seen)) begin
                    vga_req  = ($urandom_range(0, 3) != 0);
                    vga_addr = {8'h80, 8'($urandom_range(0, 255))};
                end
            end
        endcase
    end

    // ---------------- monitor ----------------
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        vga_gnt_seen = vga_gnt;
        if (!rst && mon_en) begin
            if (vga_rvalid) begin
                check("vga_rvalid_expected", vga_exp_q.size() != 0, 1);
                if (vga_exp_q.size() != 0) begin
                    check("vga_rdata", vga_rdata, vga_exp_q.pop_front());
                    check("vga_rvalid_cycle", cyc, vga_due_q.pop_front());
                end
            end
            if (vga_gnt) begin
                vga_exp_q.push_back(init_val(vga_addr));
                vga_due_q.push_back(cyc + RD_LAT);
            end
            if (vram_we) begin
                check("vram_write_expected", wr_exp_q.size() != 0, 1);
                if (wr_exp_q.size() != 0)
                    check("vram_write", {vram_addr, vram_wdata}, wr_exp_q.pop_front());
            end
            if (cpu_ack && !cpu_we) begin
                check("cpu_rd_ack_expected", cpu_rd_exp_q.size() != 0, 1);
                if (cpu_rd_exp_q.size() != 0)
                    check("cpu_rdata", cpu_rdata, cpu_rd_exp_q.pop_front());
            end
        end
    end

    // ---------------- CPU driver tasks ----------------
    // Called at posedge+1; return at posedge+1 of the cycle after the ack.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, output int ack_c);
        int t = 0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        do begin @(negedge clk); t++; end while (!cpu_ack && t < TIMEOUT);
        check("cpu_write_ack", cpu_ack, 1);
        if (cpu_ack) begin
            wr_exp_q.push_back({a, d});
            shadow[int'(a)] = d;
        end
        ack_c = cyc;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output int issue_c, output int ack_c,
                            output logic [16:0] first_bus);
        int t = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        issue_c = cyc;
        first_bus = '0;
        cpu_rd_exp_q.push_back(shadow_rd(a));
        do begin
            @(negedge clk); t++;
            if (t == 1) first_bus = {vram_we, vram_addr};
        end while (!cpu_ack && t < TIMEOUT);
        check("cpu_read_ack", cpu_ack, 1);
        ack_c = cyc;
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        summary();
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        int s, ic, ac, nlow, low_c;
        logic [16:0] fb;
        logic [16:0] low_bus;

        // Reset with both requesters active.
        rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'hFF;
        vga_req = 1'b1; vga_addr = 16'h8000;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", {cpu_ack, vga_gnt, vga_rvalid, vram_we}, 0);
        end
        vga_mode = 0; cpu_req = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("reset_state", {cpu_state_dbg, wbuf_valid_dbg}, 0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Posted write with VGA idle.
        s = cyc;
        cpu_write(16'h0012, 8'hA5, ac);
        check("t2_ack_cycle", ac, s);
        @(negedge clk);
        check("t2_drain_bus", {vram_we, vram_addr, vram_wdata}, {1'b1, 16'h0012, 8'hA5});
        @(posedge clk); #1;

        // CPU read, VGA idle.
        cpu_read(16'h0100, ic, ac, fb);
        check("t3_issue_bus", fb, {1'b0, 16'h0100});
        check("t3_latency", ac - ic, RD_LAT);
        @(negedge clk);
        check("t3_single_pulse", cpu_ack, 0);
        @(posedge clk); #1;

        // Starvation: VGA requests every cycle.
        vga_mode = 1;
        @(posedge clk); #1;
        cpu_write(16'h0040, 8'h77, ac);
        nlow = 0; low_c = -1; low_bus = '0;
        repeat (STARVE_MAX + 3) begin
            @(negedge clk);
            if (!vga_gnt) begin
                nlow++; low_c = cyc; low_bus = {vram_we, vram_addr};
            end
        end
        check("t4_gnt_low_count", nlow, 1);
        check("t4_gnt_low_cycle", low_c, ac + STARVE_MAX + 1);
        check("t4_forced_drain", low_bus, {1'b1, 16'h0040});
        vga_mode = 0;
        repeat (RD_LAT + 3) @(posedge clk);
        #1;

        // Read-after-write back to back.
        cpu_write(16'h0200, 8'h55, ac);
        cpu_read(16'h0200, ic, ac, fb);
        check("t5_drain_first", fb, {1'b1, 16'h0200});
        check("t5_latency", ac - ic, RD_LAT + 1);
        @(posedge clk); #1;

        // Reset one cycle after a read grant.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
        @(negedge clk);
        check("t6_read_grant", {vram_we, vram_addr}, {1'b0, 16'h0100});
        @(posedge clk); #1;
        rst = 1'b1; cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (RD_LAT + 2) begin
            @(negedge clk);
            check("t6_no_ack_after_reset", {cpu_ack, cpu_state_dbg, wbuf_valid_dbg}, 0);
        end
        @(posedge clk); #1;
        cpu_read(16'h0100, ic, ac, fb);
        check("t6_read_after_reset", ac - ic, RD_LAT);

        // Reset discards a buffered write.
        vga_mode = 1;
        @(posedge clk); #1;
        cpu_write(16'h0300, 8'h99, ac);
        rst = 1'b1; vga_mode = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(wr_exp_q.pop_back());
        shadow.delete(int'(16'h0300));
        vga_exp_q.delete();
        vga_due_q.delete();
        @(negedge clk);
        check("t6_wbuf_discard", {wbuf_valid_dbg, vram_we}, 0);
        @(posedge clk); #1;
        cpu_read(16'h0300, ic, ac, fb);

        // Randomized traffic against random VGA fetches.
        vga_mode = 2;
        repeat (300) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                cpu_read(a, ic, ac, fb);
                check("rand_rd_latency_bound", (ac - ic) <= (RD_LAT + 2 * STARVE_MAX + 1), 1);
            end else begin
                ic = cyc;
                cpu_write(a, 8'($urandom_range(0, 255)), ac);
                check("rand_wr_latency_bound", (ac - ic) <= STARVE_MAX, 1);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        // Let everything drain, then confirm nothing is outstanding.
        vga_mode = 0;
        repeat (STARVE_MAX + RD_LAT + 10) @(posedge clk);
        @(negedge clk);
        check("end_cpu_rd_queue", cpu_rd_exp_q.size(), 0);
        check("end_wr_queue", wr_exp_q.size(), 0);
        check("end_vga_queue", vga_exp_q.size(), 0);

        summary();
        $finish;
    end

endmodule
